// File: rtl/ap_com_lut_sched.sv
// Two-requester round-robin scheduler in front of a programmable 4-input truth-table store.
// Optional build macro AP_COM_LUT_PARITY_EN adds a per-entry even-parity bit checked on lookup.
module ap_com_lut_sched #(
  parameter int unsigned NUM_LUT = 29,
  parameter int unsigned LUT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [4:0]       cfg_addr_i,
  input  logic [LUT_W-1:0] cfg_data_i,
  output logic             cfg_err_o,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [4:0]       req0_idx_i,
  input  logic [3:0]       req0_in_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [4:0]       req1_idx_i,
  input  logic [3:0]       req1_in_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_y_o,
  output logic             rsp_id_o,
  output logic             rsp_err_o
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RESP = 1'b1} state_e;

  state_e             state_q, state_d;
  logic               rr_last_q, rr_last_d;
  logic               rsp_y_q, rsp_y_d;
  logic               rsp_id_q, rsp_id_d;
  logic               rsp_err_q, rsp_err_d;
  logic               cfg_err_q;
  logic [LUT_W-1:0]   lut_q [NUM_LUT];
  logic [NUM_LUT-1:0] prog_q;

  logic               slot_free;
  logic               gnt;
  logic               gnt_id;
  logic               cfg_in_range;
  logic [4:0]         sel_idx;
  logic [3:0]         sel_in;
  logic               look_in_range;
  logic [LUT_W-1:0]   hit_word;
  logic               hit_prog;
  logic               look_y;
  logic               look_err;

`ifdef AP_COM_LUT_PARITY_EN
  logic [NUM_LUT-1:0] par_q;
  logic               hit_par;

  function automatic logic parity_f(input logic [LUT_W-1:0] data);
    return ^data;
  endfunction
`endif

  assign cfg_in_range  = ({27'd0, cfg_addr_i} < NUM_LUT);
  assign slot_free     = (state_q == ST_IDLE) || rsp_ready_i;
  assign gnt           = slot_free && !cfg_valid_i && (req0_valid_i || req1_valid_i);

  // Reset gating keeps every ready low while rst_n is asserted.
  assign cfg_ready_o   = rst_n;
  assign req0_ready_o  = rst_n && gnt && !gnt_id;
  assign req1_ready_o  = rst_n && gnt && gnt_id;
  assign rsp_valid_o   = (state_q == ST_RESP);
  assign rsp_y_o       = rsp_y_q;
  assign rsp_id_o      = rsp_id_q;
  assign rsp_err_o     = rsp_err_q;
  assign cfg_err_o     = cfg_err_q;

  // Port selection: on a tie the port not granted last wins.
  always_comb begin
    gnt_id = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      gnt_id = ~rr_last_q;
    end else if (req1_valid_i) begin
      gnt_id = 1'b1;
    end else begin
      gnt_id = 1'b0;
    end
  end

  // Table lookup for the selected port; missing or unprogrammed entries yield an error.
  always_comb begin
    sel_idx       = gnt_id ? req1_idx_i : req0_idx_i;
    sel_in        = gnt_id ? req1_in_i : req0_in_i;
    look_in_range = ({27'd0, sel_idx} < NUM_LUT);
    hit_word      = {LUT_W{1'b0}};
    hit_prog      = 1'b0;
`ifdef AP_COM_LUT_PARITY_EN
    hit_par       = 1'b0;
`endif
    if (look_in_range) begin
      hit_word = lut_q[sel_idx];
      hit_prog = prog_q[sel_idx];
`ifdef AP_COM_LUT_PARITY_EN
      hit_par  = par_q[sel_idx];
`endif
    end else begin
      hit_word = {LUT_W{1'b0}};
      hit_prog = 1'b0;
    end
    look_err = !hit_prog;
`ifdef AP_COM_LUT_PARITY_EN
    if (hit_par != parity_f(hit_word)) begin
      look_err = 1'b1;
    end else begin
      look_err = !hit_prog;
    end
`endif
    look_y = look_err ? 1'b0 : hit_word[sel_in];
  end

  // Response FSM next state and captured response fields.
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    rsp_y_d   = rsp_y_q;
    rsp_id_d  = rsp_id_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt) state_d = ST_RESP;
        else     state_d = ST_IDLE;
      end
      ST_RESP: begin
        if (gnt)              state_d = ST_RESP;
        else if (rsp_ready_i) state_d = ST_IDLE;
        else                  state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
    if (gnt) begin
      rr_last_d = gnt_id;
      rsp_y_d   = look_y;
      rsp_id_d  = gnt_id;
      rsp_err_d = look_err;
    end else begin
      rr_last_d = rr_last_q;
    end
  end

  // FSM, arbitration pointer and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rr_last_q <= 1'b1;
      rsp_y_q   <= 1'b0;
      rsp_id_q  <= 1'b0;
      rsp_err_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      rsp_y_q   <= rsp_y_d;
      rsp_id_q  <= rsp_id_d;
      rsp_err_q <= rsp_err_d;
      cfg_err_q <= cfg_valid_i && !cfg_in_range;
    end
  end

  // Truth-table store; out-of-range writes are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LUT; i++) begin
        lut_q[i] <= {LUT_W{1'b0}};
      end
      prog_q <= {NUM_LUT{1'b0}};
`ifdef AP_COM_LUT_PARITY_EN
      par_q  <= {NUM_LUT{1'b0}};
`endif
    end else if (cfg_valid_i && cfg_in_range) begin
      lut_q[cfg_addr_i]  <= cfg_data_i;
      prog_q[cfg_addr_i] <= 1'b1;
`ifdef AP_COM_LUT_PARITY_EN
      par_q[cfg_addr_i]  <= parity_f(cfg_data_i);
`endif
    end
  end

endmodule

// File: tb/tb_ap_com_lut_sched.sv
// Self-checking bench for ap_com_lut_sched: directed scenarios plus a randomized run against a reference model.
module tb_ap_com_lut_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid, cfg_ready, cfg_err;
  logic [4:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [4:0]  req0_idx, req1_idx;
  logic [3:0]  req0_in, req1_in;
  logic        rsp_valid, rsp_ready, rsp_y, rsp_id, rsp_err;
  int checks = 0;
  int passes = 0;

  ap_com_lut_sched dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_addr_i(cfg_addr),
    .cfg_data_i(cfg_data), .cfg_err_o(cfg_err),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_idx_i(req0_idx), .req0_in_i(req0_in),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_idx_i(req1_idx), .req1_in_i(req1_in),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_y_o(rsp_y), .rsp_id_o(rsp_id),
    .rsp_err_o(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cfg_valid = 1'b0; cfg_addr = 5'd0; cfg_data = 16'h0000;
    req0_valid = 1'b0; req0_idx = 5'd0; req0_in = 4'd0;
    req1_valid = 1'b0; req1_idx = 5'd0; req1_in = 4'd0;
    rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++; if (cfg_ready !== 1'b0) $display("FAIL reset_cfg_ready got=%b exp=0", cfg_ready); else passes++;
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) $display("FAIL reset_req_ready got=%b%b exp=00", req0_ready, req1_ready); else passes++;
    checks++; if ({rsp_valid, rsp_y, rsp_id, rsp_err, cfg_err} !== 5'b00000) $display("FAIL reset_outputs got=%b exp=00000", {rsp_valid, rsp_y, rsp_id, rsp_err, cfg_err}); else passes++;
    tick();
    idle_inputs();
    rst_n = 1'b1;
    #1;
    checks++; if (cfg_ready !== 1'b1) $display("FAIL release_cfg_ready got=%b exp=1", cfg_ready); else passes++;
    tick();
  endtask

  task automatic test_unprogrammed();
    do_reset();
    req0_valid = 1'b1; req0_idx = 5'd3; req0_in = 4'b0101; rsp_ready = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1) $display("FAIL unprog_ready got=%b exp=1", req0_ready); else passes++;
    tick();
    req0_valid = 1'b0;
    checks++; if ({rsp_valid, rsp_y, rsp_err, rsp_id} !== 4'b1010) $display("FAIL unprog_rsp got=%b exp=1010", {rsp_valid, rsp_y, rsp_err, rsp_id}); else passes++;
    tick();
    checks++; if (rsp_valid !== 1'b0) $display("FAIL unprog_retire got=%b exp=0", rsp_valid); else passes++;
  endtask

  task automatic test_lookup();
    cfg_valid = 1'b1; cfg_addr = 5'd0; cfg_data = 16'h9F0E;
    req0_valid = 1'b1; req0_idx = 5'd0; req0_in = 4'b0001; rsp_ready = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b0) $display("FAIL lookup_cfg_blocks got=%b exp=0", req0_ready); else passes++;
    tick();
    cfg_valid = 1'b0;
    #1;
    checks++; if (req0_ready !== 1'b1) $display("FAIL lookup_ready got=%b exp=1", req0_ready); else passes++;
    tick();
    checks++; if ({rsp_valid, rsp_y, rsp_err, cfg_err} !== 4'b1100) $display("FAIL lookup_in1 got=%b exp=1100", {rsp_valid, rsp_y, rsp_err, cfg_err}); else passes++;
    req0_in = 4'b0100;
    tick();
    req0_valid = 1'b0;
    checks++; if ({rsp_valid, rsp_y, rsp_err} !== 3'b100) $display("FAIL lookup_in4 got=%b exp=100", {rsp_valid, rsp_y, rsp_err}); else passes++;
    tick();
  endtask

  task automatic test_back_to_back();
    bit exp_id;
    do_reset();
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_id = i[0];
      #1;
      checks++; if (req0_ready !== !exp_id || req1_ready !== exp_id) $display("FAIL rr_ready[%0d] got=%b%b exp_id=%0d", i, req0_ready, req1_ready, exp_id); else passes++;
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== exp_id) $display("FAIL rr_rsp[%0d] got v=%b id=%b exp v=1 id=%0d", i, rsp_valid, rsp_id, exp_id); else passes++;
    end
    idle_inputs(); rsp_ready = 1'b1;
    tick();
  endtask

  task automatic test_cfg_priority();
    idle_inputs();
    cfg_valid = 1'b1; cfg_addr = 5'd5; cfg_data = 16'hA5A5;
    tick();
    cfg_addr = 5'd31; cfg_data = 16'hFFFF;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    checks++; if ({cfg_ready, req0_ready, req1_ready} !== 3'b100) $display("FAIL cfg_prio got=%b exp=100", {cfg_ready, req0_ready, req1_ready}); else passes++;
    checks++; if (cfg_err !== 1'b0) $display("FAIL cfg_inrange_err got=%b exp=0", cfg_err); else passes++;
    tick();
    idle_inputs(); rsp_ready = 1'b1;
    checks++; if (cfg_err !== 1'b1) $display("FAIL cfg_err_pulse got=%b exp=1", cfg_err); else passes++;
    req0_valid = 1'b1; req0_idx = 5'd5; req0_in = 4'd0;
    tick();
    checks++; if (cfg_err !== 1'b0) $display("FAIL cfg_err_clear got=%b exp=0", cfg_err); else passes++;
    checks++; if ({rsp_valid, rsp_y, rsp_err} !== 3'b110) $display("FAIL cfg_idx5_in0 got=%b exp=110", {rsp_valid, rsp_y, rsp_err}); else passes++;
    req0_idx = 5'd31;
    tick();
    req0_valid = 1'b0;
    checks++; if ({rsp_valid, rsp_y, rsp_err} !== 3'b101) $display("FAIL cfg_idx31 got=%b exp=101", {rsp_valid, rsp_y, rsp_err}); else passes++;
    tick();
  endtask

  task automatic test_stall();
    idle_inputs();
    req0_valid = 1'b1; req0_idx = 5'd5; req0_in = 4'd0;
    tick();
    req0_in = 4'd1;
    req1_valid = 1'b1; req1_idx = 5'd5; req1_in = 4'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) $display("FAIL stall_ready[%0d] got=%b%b exp=00", i, req0_ready, req1_ready); else passes++;
      checks++; if ({rsp_valid, rsp_y, rsp_id, rsp_err} !== 4'b1100) $display("FAIL stall_hold[%0d] got=%b exp=1100", i, {rsp_valid, rsp_y, rsp_id, rsp_err}); else passes++;
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) $display("FAIL stall_release got=%b%b exp=01", req0_ready, req1_ready); else passes++;
    tick();
    idle_inputs(); rsp_ready = 1'b1;
    checks++; if ({rsp_valid, rsp_y, rsp_id, rsp_err} !== 4'b1110) $display("FAIL stall_next got=%b exp=1110", {rsp_valid, rsp_y, rsp_id, rsp_err}); else passes++;
    tick();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    cfg_valid = 1'b1; cfg_addr = 5'd0; cfg_data = 16'h9F0E;
    tick();
    idle_inputs();
    req0_valid = 1'b1; req0_idx = 5'd0; req0_in = 4'b0001;
    tick();
    req0_valid = 1'b0;
    checks++; if ({rsp_valid, rsp_y, rsp_err} !== 3'b110) $display("FAIL mid_before got=%b exp=110", {rsp_valid, rsp_y, rsp_err}); else passes++;
    rst_n = 1'b0;
    req0_valid = 1'b1;
    #1;
    checks++; if ({rsp_valid, cfg_ready, req0_ready} !== 3'b000) $display("FAIL mid_reset got=%b exp=000", {rsp_valid, cfg_ready, req0_ready}); else passes++;
    tick();
    idle_inputs();
    rst_n = 1'b1;
    tick();
    checks++; if (rsp_valid !== 1'b0) $display("FAIL mid_no_replay got=%b exp=0", rsp_valid); else passes++;
    req0_valid = 1'b1; req0_idx = 5'd0; req0_in = 4'b0001; rsp_ready = 1'b1;
    tick();
    idle_inputs(); rsp_ready = 1'b1;
    checks++; if ({rsp_valid, rsp_y, rsp_err} !== 3'b101) $display("FAIL mid_cleared got=%b exp=101", {rsp_valid, rsp_y, rsp_err}); else passes++;
    tick();
  endtask

  task automatic test_random();
    bit [15:0] m_tbl [32];
    bit        m_prog [32];
    bit        m_held, m_y, m_id, m_err, m_cfgerr, m_last, ok;
    int        g;
    int        idx;
    int        sel_in;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      m_tbl[i] = 16'h0000;
      m_prog[i] = 1'b0;
    end
    m_held = 1'b0; m_y = 1'b0; m_id = 1'b0; m_err = 1'b0; m_cfgerr = 1'b0; m_last = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      cfg_valid  = ($urandom_range(0, 3) == 0);
      cfg_addr   = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(29, 31)) : 5'($urandom_range(0, 7));
      cfg_data   = 16'($urandom);
      req0_valid = 1'($urandom_range(0, 1));
      req0_idx   = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(28, 31)) : 5'($urandom_range(0, 7));
      req0_in    = 4'($urandom);
      req1_valid = 1'($urandom_range(0, 1));
      req1_idx   = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(28, 31)) : 5'($urandom_range(0, 7));
      req1_in    = 4'($urandom);
      rsp_ready  = ($urandom_range(0, 3) != 0);
      #1;
      ok = (!m_held || rsp_ready) && !cfg_valid;
      g = -1;
      if (ok && req0_valid && req1_valid) g = m_last ? 0 : 1;
      else if (ok && req0_valid) g = 0;
      else if (ok && req1_valid) g = 1;
      checks++; if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) $display("FAIL rand_ready[%0d] got=%b%b exp_port=%0d", cyc, req0_ready, req1_ready, g); else passes++;
      tick();
      if (g >= 0) begin
        idx    = (g == 0) ? int'(req0_idx) : int'(req1_idx);
        sel_in = (g == 0) ? int'(req0_in) : int'(req1_in);
        m_held = 1'b1;
        m_id   = (g == 1);
        m_err  = (idx >= 29) || !m_prog[idx];
        m_y    = m_err ? 1'b0 : m_tbl[idx][sel_in];
        m_last = (g == 1);
      end else if (rsp_ready) begin
        m_held = 1'b0;
      end
      m_cfgerr = cfg_valid && (cfg_addr >= 5'd29);
      if (cfg_valid && cfg_addr < 5'd29) begin
        m_tbl[cfg_addr]  = cfg_data;
        m_prog[cfg_addr] = 1'b1;
      end
      checks++; if (rsp_valid !== m_held) $display("FAIL rand_valid[%0d] got=%b exp=%b", cyc, rsp_valid, m_held); else passes++;
      checks++; if (cfg_err !== m_cfgerr) $display("FAIL rand_cfg_err[%0d] got=%b exp=%b", cyc, cfg_err, m_cfgerr); else passes++;
      if (m_held) begin
        checks++; if ({rsp_y, rsp_id, rsp_err} !== {m_y, m_id, m_err}) $display("FAIL rand_rsp[%0d] got=%b exp=%b", cyc, {rsp_y, rsp_id, rsp_err}, {m_y, m_id, m_err}); else passes++;
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_unprogrammed();
    test_lookup();
    test_back_to_back();
    test_cfg_priority();
    test_stall();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/ap_com_lut_sched.md
AP_COM_LUT_SCHED -- requirements
Module: ap_com_lut_sched

Interface
REQ-001: Parameter NUM_LUT, default 29, is the number of programmable compressor truth-table entries (indices 0..NUM_LUT-1).
REQ-002: Parameter LUT_W, default 16, is the truth-table width in bits (one bit per 4-input minterm).
REQ-003: clk  input  1  single clock; all state updates on its rising edge.
REQ-004: rst_n  input  1  asynchronous, active-low reset.
REQ-005: cfg_valid / cfg_ready  input / output  1 / 1  configuration write handshake.
REQ-006: cfg_addr / cfg_data  input / input  5 / LUT_W  entry index and truth table (bit k = y for {a,b,c,d}=k).
REQ-007: cfg_err  output  1  one-cycle pulse; accepted write had out-of-range address.
REQ-008: req0_valid / req0_ready  input / output  1 / 1  requester 0 evaluation handshake.
REQ-009: req0_idx / req0_in  input / input  5 / 4  requester 0 entry index and {a,b,c,d}.
REQ-010: req1_valid, req1_ready, req1_idx, req1_in  same as REQ-008..009 for requester 1.
REQ-011: rsp_valid / rsp_ready  output / input  1 / 1  response handshake.
REQ-012: rsp_y / rsp_id / rsp_err  output  1 / 1 / 1  result bit, granted requester, error flag.

Function
REQ-013: 2- and 3-input entries SHALL use in[1:0] / in[2:0] with upper in bits driven 0 by requesters; block does no masking.
REQ-014: FSM states: IDLE (no response held), RESP (rsp_valid=1); IDLE->RESP on request grant; RESP->IDLE on rsp_ready without new grant; RESP->RESP on rsp_ready with same-cycle grant.
REQ-015: Grant possible only when (state==IDLE or rsp_ready) and cfg_valid==0.
REQ-016: cfg_ready = 1 whenever not in reset; config has absolute priority; while cfg_valid=1, req0_ready=req1_ready=0.
REQ-017: Round-robin: both requests valid -> grant port not granted last; pointer updates only on grant; after reset port 0 wins first tie.
REQ-018: Only granted port's ready is 1; single request valid -> that port granted if REQ-015 holds.
REQ-019: Latency: request accepted cycle N -> rsp_valid, rsp_y, rsp_id, rsp_err registered, visible cycle N+1, held stable until rsp_ready.
REQ-020: rsp_y = table[idx][in]; per-entry programmed bit set on accepted in-range write.
REQ-021: idx >= NUM_LUT or entry unprogrammed -> rsp_y=0, rsp_err=1.
REQ-022: Config write accepted cycle N affects lookups for requests granted at N+1 onward; rewrites overwrite.
REQ-023: cfg_addr >= NUM_LUT -> write dropped, cfg_err=1 for cycle N+1 only.
REQ-024: Zero-bubble throughput: one response per cycle when rsp_ready held 1 and no config traffic.

Reset
REQ-025: rst_n=0 SHALL immediately clear: all tables to 0, all programmed bits, FSM to IDLE, RR pointer to "port 1 last", rsp_valid, rsp_y, rsp_id, rsp_err, cfg_err = 0.
REQ-026: Reset mid-response SHALL drop the held response; no response replayed after reset release.
REQ-027: While rst_n=0, cfg_ready, req0_ready, req1_ready SHALL be 0.

Configuration
REQ-028: Macro AP_COM_LUT_PARITY_EN defined: per-entry even-parity bit stored on write; lookup with parity mismatch -> rsp_err=1, rsp_y=0.
REQ-029: AP_COM_LUT_PARITY_EN undefined: no parity storage; rsp_err per REQ-021 only; all other behaviour identical.

Verification
REQ-030: After reset, req0 idx=3 in=4'b0101 -> next cycle rsp_valid=1, rsp_y=0, rsp_err=1, rsp_id=0.
REQ-031: Write addr=0 data=16'h9F0E, then req0 idx=0 in=4'b0001 -> rsp_y=1, rsp_err=0; in=4'b0100 -> rsp_y=0.
REQ-032: req0 and req1 both valid 4 cycles, rsp_ready=1 -> rsp_id sequence 0,1,0,1; one response per cycle.
REQ-033: cfg_valid=1 with both requests valid -> both readies 0 that cycle; write addr=31 -> cfg_err pulse next cycle, no table change.
REQ-034: rsp_ready=0 for 3 cycles with response held -> rsp_* stable, req readies 0; rsp_ready=1 -> next grant same cycle.
REQ-035: rst_n low while rsp_valid=1 -> rsp_valid=0 immediately; after release idx=0 lookup returns rsp_err=1.
